// File: rtl/nibble_serial_adder.sv
// Nibble-serial adder: adds two 4*NIBBLES-bit operands plus carry-in, one
// 4-bit ripple slice per clock, then reports sum, carry-out and signed overflow.
module nibble_serial_adder #(
    parameter int NIBBLES = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    input  logic                   c_in,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   sum,
    output logic                   c_out,
    output logic                   overflow
);

    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        DONE
    } state_t;

    state_t           state;
    logic [W-1:0]     a_q;
    logic [W-1:0]     b_q;
    logic             carry;
    logic [IDX_W-1:0] idx;

    logic [3:0]       a_nib;
    logic [3:0]       b_nib;
    logic [4:0]       nib_full;
    logic [3:0]       low_full;
    logic             msb_carry_in;

    // NOTE: every variable driven here gets a value on every path, so no latch is inferred.
    always_comb begin
        a_nib        = a_q[4*idx +: 4];
        b_nib        = b_q[4*idx +: 4];
        nib_full     = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0, carry};
        // Carry into bit 3 of the slice; only meaningful for the top nibble's overflow.
        low_full     = {1'b0, a_nib[2:0]} + {1'b0, b_nib[2:0]} + {3'b0, carry};
        msb_carry_in = low_full[3];
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            sum      <= '0;
            c_out    <= 1'b0;
            overflow <= 1'b0;
            idx      <= '0;
            carry    <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q   <= a;
                        b_q   <= b;
                        carry <= c_in;
                        idx   <= '0;
                        sum   <= '0;
                        busy  <= 1'b1;
                        state <= ADD;
                    end
                end
                ADD: begin
                    sum[4*idx +: 4] <= nib_full[3:0];
                    carry           <= nib_full[4];
                    idx             <= idx + IDX_W'(1);
                    if (idx == LAST_IDX) begin
                        c_out    <= nib_full[4];
                        overflow <= msb_carry_in ^ nib_full[4];
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder: fixed vectors, random operands
// against an arithmetic reference, and multi-cycle reset/start corner cases.
module tb_nibble_serial_adder;

    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         c_in_s;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         c_out;
    logic         overflow;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] exp_sum;
        logic         exp_cout;
        logic         exp_ovf;
    } vec_t;

    vec_t vecs[6];

    nibble_serial_adder #(.NIBBLES(NIBBLES)) dut (
        .clock   (clk),
        .reset   (reset),
        .start   (start),
        .a       (a_in),
        .b       (b_in),
        .c_in    (c_in_s),
        .busy    (busy),
        .done    (done),
        .sum     (sum),
        .c_out   (c_out),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mc,
                                  output logic [W-1:0] ms, output logic mco, output logic mov);
        logic [W:0] full;
        full = {1'b0, ma} + {1'b0, mb} + {{W{1'b0}}, mc};
        ms   = full[W-1:0];
        mco  = full[W];
        mov  = (ma[W-1] == mb[W-1]) && (ms[W-1] != ma[W-1]);
    endfunction

    // Called at a negedge; returns at a negedge one cycle after the done pulse.
    task automatic do_add(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                          input logic [W-1:0] es, input logic ec, input logic eo, input string name);
        int busy_cnt;
        int n;
        a_in   = ta;
        b_in   = tb_v;
        c_in_s = tc;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({name, " accept"}, busy, 1);
        // Operands change after acceptance and must not disturb the result.
        a_in   = W'($urandom);
        b_in   = W'($urandom);
        c_in_s = 1'($urandom);
        busy_cnt = 0;
        n = 0;
        while (!done && n < 20) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            n++;
        end
        check({name, " done seen"}, done, 1);
        check({name, " busy cycles"}, busy_cnt, NIBBLES);
        check({name, " busy low at done"}, busy, 0);
        check({name, " sum"}, sum, es);
        check({name, " c_out"}, c_out, ec);
        check({name, " overflow"}, overflow, eo);
        @(negedge clk);
        check({name, " done one cycle"}, done, 0);
        check({name, " sum held"}, sum, es);
    endtask

    initial begin
        logic [W-1:0] ra, rb, ms, first_sum;
        logic         rc, mco, mov;
        int           done_cnt, first_cyc, n;

        vecs[0] = '{16'h0001, 16'hFFFF, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[2] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[3] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0};
        vecs[4] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
        vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};

        reset = 1'b1; start = 1'b0; a_in = '0; b_in = '0; c_in_s = 1'b0;
        repeat (3) @(negedge clk);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset sum", sum, 0);
        check("reset c_out", c_out, 0);
        check("reset overflow", overflow, 0);
        reset = 1'b0;

        // First start is issued for the very first edge after reset release.
        for (int i = 0; i < 6; i++)
            do_add(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].exp_sum,
                   vecs[i].exp_cout, vecs[i].exp_ovf, $sformatf("vec%0d", i));

        for (int i = 0; i < 16; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            if (i == 0) begin ra = 16'h7FFF; rb = 16'h7FFF; end
            model(ra, rb, rc, ms, mco, mov);
            do_add(ra, rb, rc, ms, mco, mov, $sformatf("rand%0d", i));
        end

        // Reset after a completed add clears the held result.
        do_add(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, "pre_reset");
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("post reset sum", sum, 0);
        check("post reset c_out", c_out, 0);

        // Reset in the middle of ADD discards the partial result.
        a_in = 16'h00FF; b_in = 16'h0001; c_in_s = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midadd reset busy", busy, 0);
        check("midadd reset done", done, 0);
        check("midadd reset sum", sum, 0);
        done_cnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check("midadd no done", done_cnt, 0);

        // start pulses during ADD and DONE are ignored.
        a_in = 16'h0003; b_in = 16'h0004; c_in_s = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a_in = 16'hFFFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("ignore done seen", done, 1);
        check("ignore sum", sum, 16'h0007);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("ignore idle busy", busy, 0);
        check("ignore idle done", done, 0);
        repeat (3) @(negedge clk);
        check("ignore no restart", busy, 0);
        check("ignore sum kept", sum, 16'h0007);

        // start held high: back-to-back additions every NIBBLES+2 cycles.
        a_in = 16'h1111; b_in = 16'h2222; c_in_s = 1'b0; start = 1'b1;
        @(negedge clk);
        a_in = 16'hABCD; b_in = 16'h1234; c_in_s = 1'b1;
        done_cnt = 0;
        first_cyc = 0;
        first_sum = '0;
        for (int cyc = 1; cyc <= 20 && done_cnt < 2; cyc++) begin
            if (done) begin
                done_cnt++;
                if (done_cnt == 1) begin
                    first_cyc = cyc;
                    first_sum = sum;
                    model(16'h1111, 16'h2222, 1'b0, ms, mco, mov);
                    check("b2b sum1", sum, ms);
                end else begin
                    check("b2b spacing", cyc - first_cyc, NIBBLES + 2);
                    model(16'hABCD, 16'h1234, 1'b1, ms, mco, mov);
                    check("b2b sum2", sum, ms);
                    check("b2b c_out2", c_out, mco);
                    start = 1'b0;
                end
            end else if (done_cnt == 1 && cyc == first_cyc + 1) begin
                check("b2b held in idle", sum, first_sum);
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("b2b two pulses", done_cnt, 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
